// File: rtl/div_sequencer_if.sv
// Request/response handshake bundle between the issue stage and div_sequencer.
// Master drives requests and accepts responses; slave is the sequencer.
interface div_sequencer_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [XLEN-1:0]  req_a;
  logic [XLEN-1:0]  req_b;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [XLEN-1:0]  rsp_data;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_tag
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_tag
  );
endinterface

// File: rtl/div_sequencer.sv
// Issue-side controller for the iterative divider: bypasses div-by-zero and
// signed overflow, reuses the last quotient/remainder pair, sequences launches.
module div_sequencer #(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 5,
  parameter int MAX_LAT = 96
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  div_sequencer_if.slave  bus,
  output logic            timeout_err,
  output logic            div_start,
  output logic            div_signed,
  output logic [XLEN-1:0] div_dividend,
  output logic [XLEN-1:0] div_divisor,
  input  logic            div_valid,
  input  logic [XLEN-1:0] div_quotient,
  input  logic [XLEN-1:0] div_rem
);

  localparam int WD_W = $clog2(MAX_LAT + 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LAUNCH = 3'd1;
  localparam logic [2:0] WAIT   = 3'd2;
  localparam logic [2:0] RESP   = 3'd3;
  localparam logic [2:0] DRAIN  = 3'd4;

  logic [2:0]       state;
  logic             op_rem;
  logic [WD_W-1:0]  wdog;
  logic [XLEN-1:0]  rsp_data;
  logic [TAG_W-1:0] rsp_tag;

  logic             c_vld;
  logic             c_sgn;
  logic [XLEN-1:0]  c_a;
  logic [XLEN-1:0]  c_b;
  logic [XLEN-1:0]  c_q;
  logic [XLEN-1:0]  c_r;

  logic accept;
  logic req_sgn;
  logic req_rem;
  logic b_zero;
  logic ovf;
  logic hit;

  assign bus.req_ready = (state == IDLE) && !flush;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_data  = rsp_data;
  assign bus.rsp_tag   = rsp_tag;
  assign div_start     = (state == LAUNCH);

  assign accept  = bus.req_valid && bus.req_ready;
  assign req_sgn = !bus.req_op[0];
  assign req_rem = bus.req_op[1];
  assign b_zero  = (bus.req_b == '0);
  assign ovf     = req_sgn && (bus.req_a == INT_MIN)
                && (bus.req_b == '1);
  // The cache only ever holds launched operands, so a hit
  // never overlaps the two bypass cases.
  assign hit     = c_vld && !b_zero && !ovf
                && (c_a == bus.req_a)
                && (c_b == bus.req_b)
                && (c_sgn == req_sgn);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      op_rem       <= 1'b0;
      wdog         <= '0;
      rsp_data     <= '0;
      rsp_tag      <= '0;
      div_dividend <= '0;
      div_divisor  <= '0;
      div_signed   <= 1'b0;
      timeout_err  <= 1'b0;
      c_vld        <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      if (flush) c_vld <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            rsp_tag <= bus.req_tag;
            unique case (1'b1)
              b_zero: begin
                rsp_data <= req_rem ? bus.req_a : '1;
                state    <= RESP;
              end
              ovf: begin
                rsp_data <= req_rem ? '0 : INT_MIN;
                state    <= RESP;
              end
              hit: begin
                rsp_data <= req_rem ? c_r : c_q;
                state    <= RESP;
              end
              default: begin
                div_dividend <= bus.req_a;
                div_divisor  <= bus.req_b;
                div_signed   <= req_sgn;
                op_rem       <= req_rem;
                state        <= LAUNCH;
              end
            endcase
          end
        end
        LAUNCH: begin
          wdog  <= '0;
          state <= flush ? DRAIN : WAIT;
        end
        WAIT: begin
          // A flush landing with div_valid has nothing left to drain.
          if (flush) begin
            state <= div_valid ? IDLE : DRAIN;
          end else if (div_valid) begin
            c_vld    <= 1'b1;
            c_a      <= div_dividend;
            c_b      <= div_divisor;
            c_sgn    <= div_signed;
            c_q      <= div_quotient;
            c_r      <= div_rem;
            rsp_data <= op_rem ? div_rem : div_quotient;
            state    <= RESP;
          end else if (wdog == WD_W'(MAX_LAT - 1)) begin
            timeout_err <= 1'b1;
            c_vld       <= 1'b0;
            state       <= DRAIN;
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end
        RESP: begin
          if (flush || bus.rsp_ready) state <= IDLE;
        end
        DRAIN: begin
          if (div_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed plus randomized bench for div_sequencer with a behavioural
// divider model and a reference model of results, latency and reuse.
module tb_div_sequencer;

  localparam logic [31:0] MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL1 = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        timeout_err;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_valid = 1'b0;
  logic [31:0] div_quotient = '0;
  logic [31:0] div_rem = '0;

  div_sequencer_if #(.XLEN(32), .TAG_W(5)) bus ();

  div_sequencer #(.XLEN(32), .TAG_W(5), .MAX_LAT(96)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .bus          (bus),
    .timeout_err  (timeout_err),
    .div_start    (div_start),
    .div_signed   (div_signed),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_valid    (div_valid),
    .div_quotient (div_quotient),
    .div_rem      (div_rem)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  bit          busy = 1'b0;
  int          cnt = 0;
  int          starts = 0;
  int          last_lat = 0;
  int          lat_fix = 0;
  logic [31:0] cap_a = '0;
  logic [31:0] cap_b = '0;
  logic        cap_s = 1'b0;
  bit          opnd_bad = 1'b0;
  int          sa;
  int          sb;

  bit          cm_vld = 1'b0;
  logic [31:0] cm_a = '0;
  logic [31:0] cm_b = '0;
  bit          cm_s = 1'b0;

  // External divider: samples operands at div_start, answers after a latency.
  initial begin : divider
    forever begin
      @(negedge clk);
      div_valid = 1'b0;
      if (!rst_n) begin
        busy = 1'b0;
      end else begin
        if (busy) begin
          if (div_dividend !== cap_a || div_divisor !== cap_b
              || div_signed !== cap_s) opnd_bad = 1'b1;
          cnt--;
          if (cnt == 0) begin
            busy = 1'b0;
            div_valid = 1'b1;
            sa = cap_a;
            sb = cap_b;
            if (cap_b == 0) begin
              div_quotient = ALL1;
              div_rem = cap_a;
            end else if (cap_s && cap_a == MIN && cap_b == ALL1) begin
              div_quotient = MIN;
              div_rem = '0;
            end else if (cap_s) begin
              div_quotient = 32'(sa / sb);
              div_rem = 32'(sa % sb);
            end else begin
              div_quotient = cap_a / cap_b;
              div_rem = cap_a % cap_b;
            end
          end
        end
        if (div_start) begin
          busy = 1'b1;
          starts++;
          cap_a = div_dividend;
          cap_b = div_divisor;
          cap_s = div_signed;
          cnt = (lat_fix != 0) ? lat_fix : int'($urandom_range(3, 12));
          last_lat = cnt;
        end
      end
    end
  end

  initial begin : global_bound
    #600000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  function automatic logic [31:0] ref_res(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    int x;
    int y;
    bit sg;
    bit rm;
    sg = !op[0];
    rm = op[1];
    x = a;
    y = b;
    if (b == 0) return rm ? a : ALL1;
    if (sg && a == MIN && b == ALL1) return rm ? 32'h0 : MIN;
    if (sg) return rm ? 32'(x % y) : 32'(x / y);
    return rm ? a % b : a / b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag);
    int n;
    n = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op = op;
    bus.req_a = a;
    bus.req_b = b;
    bus.req_tag = tag;
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("accept_bound", 32'(n), 32'd0);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic run_req(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag,
                         input int hold);
    bit sg;
    bit byp;
    bit hit;
    bit ok;
    int s0;
    int n;
    int exp_lat;
    logic [31:0] exp;
    sg = !op[0];
    byp = (b == 0) || (sg && a == MIN && b == ALL1);
    hit = !byp && cm_vld && cm_a == a && cm_b == b && cm_s == sg;
    exp = ref_res(op, a, b);
    s0 = starts;
    opnd_bad = 1'b0;
    issue(op, a, b, tag);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rsp_valid && n < 300);
    exp_lat = (byp || hit) ? 1 : last_lat + 2;
    chk("latency", 32'(n), 32'(exp_lat));
    chk("rsp_data", bus.rsp_data, exp);
    chk("rsp_tag", 32'(bus.rsp_tag), 32'(tag));
    chk("div_starts", 32'(starts - s0), (byp || hit) ? 32'd0 : 32'd1);
    chk("opnd_hold", 32'(opnd_bad), 32'd0);
    chk("rdy_in_rsp", 32'(bus.req_ready), 32'd0);
    if (!byp && !hit) begin
      cm_vld = 1'b1;
      cm_a = a;
      cm_b = b;
      cm_s = sg;
    end
    ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!bus.rsp_valid || bus.rsp_data !== exp
          || bus.rsp_tag !== tag || bus.req_ready) ok = 1'b0;
    end
    if (hold > 0) chk("rsp_stable", 32'(ok), 32'd1);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("rsp_drop", 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin : stim
    bit ok;
    int n;
    int s0;
    int tcnt;
    int tpos;
    int rs;
    logic [1:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] la;
    logic [31:0] lb;
    int mode;

    bus.req_valid = 1'b0;
    bus.req_op = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_tag = '0;
    bus.rsp_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_div_start", 32'(div_start), 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    chk("rst_dividend", div_dividend, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(bus.req_ready), 32'd1);

    run_req(2'b01, 32'd100, 32'd7, 5'd3, 0);
    run_req(2'b00, 32'hFFFF_FF9C, 32'd7, 5'd4, 0);
    run_req(2'b10, 32'hFFFF_FF9C, 32'd7, 5'd5, 0);
    run_req(2'b11, 32'h1234, 32'd0, 5'd6, 0);
    run_req(2'b00, 32'h55, 32'd0, 5'd7, 0);
    run_req(2'b00, MIN, ALL1, 5'd8, 0);
    run_req(2'b10, MIN, ALL1, 5'd9, 20);
    run_req(2'b01, 32'hDEAD_BEEF, 32'd13, 5'd10, 20);

    // flush mid-WAIT kills the op and the cached pair
    run_req(2'b01, 32'd5000, 32'd9, 5'd11, 0);
    lat_fix = 25;
    issue(2'b00, 32'hABCD_0001, 32'd3, 5'd12);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    ok = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
      if (busy && (bus.req_ready || bus.rsp_valid)) ok = 1'b0;
    end while (busy && n < 100);
    chk("flush_blocks", 32'(ok), 32'd1);
    chk("drain_bound", 32'(busy), 32'd0);
    @(negedge clk);
    chk("drain_idle", 32'(bus.req_ready), 32'd1);
    chk("drain_no_rsp", 32'(bus.rsp_valid), 32'd0);
    cm_vld = 1'b0;
    lat_fix = 0;
    run_req(2'b01, 32'd5000, 32'd9, 5'd13, 0);
    run_req(2'b00, 32'hABCD_0001, 32'd3, 5'd14, 0);

    // flush while idle: request refused and cache dropped
    run_req(2'b00, 32'h0F0F_0F0F, 32'd77, 5'd15, 0);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op = 2'b10;
    flush = 1'b1;
    #1 chk("flush_no_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    bus.req_valid = 1'b0;
    cm_vld = 1'b0;
    run_req(2'b10, 32'h0F0F_0F0F, 32'd77, 5'd16, 0);

    // watchdog
    run_req(2'b01, 32'd100, 32'd7, 5'd17, 0);
    lat_fix = 110;
    issue(2'b00, 32'h55, 32'd3, 5'd18);
    n = 0;
    tcnt = 0;
    tpos = 0;
    rs = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
      if (timeout_err) begin
        tcnt++;
        tpos = n;
      end
      if (bus.rsp_valid) rs++;
    end while (busy && n < 200);
    chk("timeout_pulses", 32'(tcnt), 32'd1);
    chk("timeout_cycle", 32'(tpos), 32'd98);
    chk("timeout_no_rsp", 32'(rs), 32'd0);
    @(negedge clk);
    chk("timeout_idle", 32'(bus.req_ready), 32'd1);
    cm_vld = 1'b0;
    lat_fix = 0;
    run_req(2'b01, 32'd100, 32'd7, 5'd19, 0);

    // reset mid-WAIT
    lat_fix = 30;
    issue(2'b00, 32'h777, 32'd5, 5'd9);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mrst_div_start", 32'(div_start), 32'd0);
    chk("mrst_timeout", 32'(timeout_err), 32'd0);
    chk("mrst_rsp_data", bus.rsp_data, 32'd0);
    chk("mrst_rsp_tag", 32'(bus.rsp_tag), 32'd0);
    chk("mrst_dividend", div_dividend, 32'd0);
    chk("mrst_divisor", div_divisor, 32'd0);
    chk("mrst_signed", 32'(div_signed), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    lat_fix = 0;
    cm_vld = 1'b0;
    run_req(2'b00, 32'h777, 32'd5, 5'd20, 0);

    la = 32'd1;
    lb = 32'd1;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      mode = $urandom_range(0, 9);
      a = $urandom;
      b = $urandom;
      if (mode == 0) b = '0;
      else if (mode == 1) begin
        a = MIN;
        b = ALL1;
      end else if (mode < 4) begin
        a = la;
        b = lb;
      end else if (mode < 7) b = $urandom_range(1, 300);
      run_req(op, a, b, 5'($urandom_range(0, 31)),
              $urandom_range(0, 3));
      la = a;
      lb = b;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
